// File: rtl/port_master_if.sv
// Command/response handshake plus port strobe bus for port_master; cmd_rmw/cmd_mask
// exist only when PORT_MASTER_RMW_EN is defined. master = port_master's view.
interface port_master_if #(
  parameter int NPORTS = 12,
  parameter int DW     = 16,
  parameter int AW     = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [AW-1:0]     cmd_addr;
  logic [DW-1:0]     cmd_wdata;
`ifdef PORT_MASTER_RMW_EN
  logic              cmd_rmw;
  logic [DW-1:0]     cmd_mask;
`endif
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic [NPORTS-1:0] read;
  logic [NPORTS-1:0] write;
  logic [DW-1:0]     wdata;
  logic [DW-1:0]     rdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, rdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, read, write, wdata
`ifdef PORT_MASTER_RMW_EN
    , input cmd_rmw, cmd_mask
`endif
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, rdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, read, write, wdata
`ifdef PORT_MASTER_RMW_EN
    , output cmd_rmw, cmd_mask
`endif
  );
endinterface

// File: rtl/port_master.sv
// Register-port bus initiator: one command in flight, strobe at T+1, response at T+1 (error),
// T+2 (write) or T+2+RD_LAT (read), held until rsp_ready. Read-modify-write: PORT_MASTER_RMW_EN.
module port_master #(
  parameter int NPORTS = 12,
  parameter int DW     = 16,
  parameter int AW     = 4,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  port_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              accept;
  logic              addr_bad;
  logic              wait_last;
  logic              cmd_is_rmw;
  logic              rmw_first;
  logic              wr_strobe;
  logic [NPORTS-1:0] onehot;

`ifdef PORT_MASTER_RMW_EN
  logic              rmw_q, rmw_d;
  logic              phase2_q, phase2_d;
  logic [DW-1:0]     cmd_wdata_q, cmd_wdata_d;
  logic [DW-1:0]     mask_q, mask_d;

  assign cmd_is_rmw = bus.cmd_rmw & bus.cmd_write;
  // First strobe of an RMW is the read half; the write half follows WAIT.
  assign rmw_first  = rmw_q & ~phase2_q;
`else
  assign cmd_is_rmw = 1'b0;
  assign rmw_first  = 1'b0;
`endif

  assign accept    = bus.cmd_valid & bus.cmd_ready;
  assign addr_bad  = (32'(bus.cmd_addr) >= NPORTS);
  assign wait_last = (cnt_q == 3'(RD_LAT - 1));
  assign wr_strobe = wr_q & ~rmw_first;
  assign onehot    = NPORTS'(1) << addr_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = addr_bad ? RESP : STROBE;
      STROBE:  state_d = wr_strobe ? RESP : WAIT;
      WAIT:    if (wait_last) state_d = rmw_first ? STROBE : RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.read      = '0;
    bus.write     = '0;
    case (state_q)
      IDLE:    bus.cmd_ready = ~rst;
      STROBE:  if (wr_strobe) bus.write = onehot;
               else           bus.read  = onehot;
      RESP:    bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.wdata     = wdata_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  always_comb begin
    addr_d      = addr_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef PORT_MASTER_RMW_EN
    rmw_d       = rmw_q;
    phase2_d    = phase2_q;
    cmd_wdata_d = cmd_wdata_q;
    mask_d      = mask_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d      = bus.cmd_addr;
          wr_d        = bus.cmd_write;
          rsp_rdata_d = '0;
          rsp_err_d   = addr_bad;
          // wdata only moves when a write will really be issued.
          if (bus.cmd_write && !addr_bad && !cmd_is_rmw) wdata_d = bus.cmd_wdata;
`ifdef PORT_MASTER_RMW_EN
          rmw_d       = cmd_is_rmw;
          phase2_d    = 1'b0;
          cmd_wdata_d = bus.cmd_wdata;
          mask_d      = bus.cmd_mask;
`endif
        end
      end
      STROBE: cnt_d = '0;
      WAIT: begin
        cnt_d = cnt_q + 3'd1;
        if (wait_last) begin
          rsp_rdata_d = bus.rdata;
`ifdef PORT_MASTER_RMW_EN
          if (rmw_first) begin
            phase2_d = 1'b1;
            wdata_d  = (bus.rdata & ~mask_q) | (cmd_wdata_q & mask_q);
          end
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef PORT_MASTER_RMW_EN
      rmw_q       <= 1'b0;
      phase2_q    <= 1'b0;
      cmd_wdata_q <= '0;
      mask_q      <= '0;
`endif
    end else begin
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef PORT_MASTER_RMW_EN
      rmw_q       <= rmw_d;
      phase2_q    <= phase2_d;
      cmd_wdata_q <= cmd_wdata_d;
      mask_q      <= mask_d;
`endif
    end
  end
endmodule
